// File: rtl/mapu_b_arb_pkg.sv
// Shared types and constants for the MAPU job scheduler.
package mapu_b_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_A   = 3'd1,
        ST_SEND_B   = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_RETURN   = 3'd4
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/mapu_b_rr_arb.sv
// Combinational round-robin picker: first active request at or after ptr.
module mapu_b_rr_arb
    import mapu_b_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    localparam int CW = IDX_W + 1;

    logic [CW-1:0] cand;
    logic          found;

    // Walk the requesters starting at ptr, wrapping once, and keep the first hit.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                 = 1'b1;
                gnt[cand[IDX_W-1:0]]  = 1'b1;
                idx                   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mapu_b_arb.sv
// Round-robin job scheduler sharing one MAPU between NUM_REQ requesters.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no job; pick a winner when any requester is valid
// ST_SEND_A   | pass operand A beat of the granted requester to the MAPU
// ST_SEND_B   | pass operand B beat of the granted requester to the MAPU
// ST_WAIT_RSP | accept MAPU result, or abort after TIMEOUT cycles
// ST_RETURN   | present result to the owner until it takes it
module mapu_b_arb
    import mapu_b_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 256
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_vld,
    output logic [NUM_REQ-1:0]            req_rdy,
    input  logic [NUM_REQ-1:0]            req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_r0,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_r1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_r2,
    output logic [NUM_REQ-1:0]            rsp_vld,
    input  logic [NUM_REQ-1:0]            rsp_rdy,
    output logic [DATA_WIDTH-1:0]         rsp_r0,
    output logic [DATA_WIDTH-1:0]         rsp_r1,
    output logic [DATA_WIDTH-1:0]         rsp_r2,
    output logic                          rsp_of,
    output logic                          rsp_err,
    output logic                          mapu_en,
    output logic                          mapu_op,
    output logic                          mapu_i_vld,
    input  logic                          mapu_i_rdy_n,
    output logic [DATA_WIDTH-1:0]         mapu_i_r0,
    output logic [DATA_WIDTH-1:0]         mapu_i_r1,
    output logic [DATA_WIDTH-1:0]         mapu_i_r2,
    input  logic                          mapu_o_vld,
    output logic                          mapu_o_rdy,
    input  logic [DATA_WIDTH-1:0]         mapu_o_r0,
    input  logic [DATA_WIDTH-1:0]         mapu_o_r1,
    input  logic [DATA_WIDTH-1:0]         mapu_o_r2,
    input  logic                          mapu_o_of
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        ptr, gidx, win_idx;
    logic [NUM_REQ-1:0]      win_gnt;
    logic [CNT_W-1:0]        tmo_cnt;
    logic [DATA_WIDTH-1:0]   res_r0, res_r1, res_r2;
    logic                    res_of, res_err;
    logic                    grant_ld, res_ld, tmo_hit, done;

    mapu_b_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req (req_vld),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake steering and datapath load strobes.
    always_comb begin
        state_nxt  = state;
        grant_ld   = 1'b0;
        res_ld     = 1'b0;
        tmo_hit    = 1'b0;
        done       = 1'b0;
        req_rdy    = '0;
        rsp_vld    = '0;
        mapu_i_vld = 1'b0;
        mapu_o_rdy = 1'b0;
        mapu_i_r0  = '0;
        mapu_i_r1  = '0;
        mapu_i_r2  = '0;
        case (state)
            ST_IDLE: begin
                if (|req_vld) begin
                    grant_ld  = 1'b1;
                    state_nxt = ST_SEND_A;
                end
            end
            ST_SEND_A, ST_SEND_B: begin
                mapu_i_vld    = req_vld[gidx];
                req_rdy[gidx] = mapu_i_rdy_n;
                mapu_i_r0     = req_r0[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
                mapu_i_r1     = req_r1[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
                mapu_i_r2     = req_r2[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
                if (req_vld[gidx] && mapu_i_rdy_n) begin
                    state_nxt = (state == ST_SEND_A) ? ST_SEND_B : ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                mapu_o_rdy = 1'b1;
                // A response landing on the last allowed cycle beats the abort.
                if (mapu_o_vld) begin
                    res_ld    = 1'b1;
                    state_nxt = ST_RETURN;
                end else if ((TIMEOUT != 0) && (tmo_cnt == CNT_W'(TIMEOUT - 1))) begin
                    tmo_hit   = 1'b1;
                    state_nxt = ST_RETURN;
                end
            end
            ST_RETURN: begin
                rsp_vld[gidx] = 1'b1;
                if (rsp_rdy[gidx]) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Grant, control plane, watchdog and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            gidx    <= '0;
            mapu_en <= 1'b0;
            mapu_op <= OP_ADD;
            tmo_cnt <= '0;
            res_r0  <= '0;
            res_r1  <= '0;
            res_r2  <= '0;
            res_of  <= 1'b0;
            res_err <= 1'b0;
        end else begin
            if (grant_ld) begin
                gidx    <= win_idx;
                mapu_op <= (|(win_gnt & req_op)) ? OP_MUL : OP_ADD;
                mapu_en <= 1'b1;
            end
            if (state == ST_WAIT_RSP) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (res_ld) begin
                res_r0  <= mapu_o_r0;
                res_r1  <= mapu_o_r1;
                res_r2  <= mapu_o_r2;
                res_of  <= mapu_o_of;
                res_err <= 1'b0;
            end
            if (tmo_hit) begin
                res_r0  <= '0;
                res_r1  <= '0;
                res_r2  <= '0;
                res_of  <= 1'b0;
                res_err <= 1'b1;
            end
            if (done) begin
                ptr     <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                mapu_en <= 1'b0;
                tmo_cnt <= '0;
            end
        end
    end

    assign rsp_r0  = res_r0;
    assign rsp_r1  = res_r1;
    assign rsp_r2  = res_r2;
    assign rsp_of  = res_of;
    assign rsp_err = res_err;

endmodule

// File: tb/tb_mapu_b_arb.sv
// Self-checking bench for mapu_b_arb: directed table, sequences, random jobs.
`timescale 1ns/1ps
module tb_mapu_b_arb;

    localparam int DW  = 32;
    localparam int NR  = 2;
    localparam int TMO = 8;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NR-1:0]      req_vld, req_rdy, req_op, rsp_vld, rsp_rdy;
    logic [NR*DW-1:0]   req_r0, req_r1, req_r2;
    logic [DW-1:0]      rsp_r0, rsp_r1, rsp_r2;
    logic               rsp_of, rsp_err, mapu_en, mapu_op, mapu_i_vld, mapu_i_rdy_n;
    logic [DW-1:0]      mapu_i_r0, mapu_i_r1, mapu_i_r2;
    logic               mapu_o_vld, mapu_o_rdy, mapu_o_of;
    logic [DW-1:0]      mapu_o_r0, mapu_o_r1, mapu_o_r2;

    mapu_b_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
        .req_r0(req_r0), .req_r1(req_r1), .req_r2(req_r2),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_r0(rsp_r0), .rsp_r1(rsp_r1), .rsp_r2(rsp_r2),
        .rsp_of(rsp_of), .rsp_err(rsp_err),
        .mapu_en(mapu_en), .mapu_op(mapu_op),
        .mapu_i_vld(mapu_i_vld), .mapu_i_rdy_n(mapu_i_rdy_n),
        .mapu_i_r0(mapu_i_r0), .mapu_i_r1(mapu_i_r1), .mapu_i_r2(mapu_i_r2),
        .mapu_o_vld(mapu_o_vld), .mapu_o_rdy(mapu_o_rdy),
        .mapu_o_r0(mapu_o_r0), .mapu_o_r1(mapu_o_r1), .mapu_o_r2(mapu_o_r2),
        .mapu_o_of(mapu_o_of)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              op;
        logic [2:0][DW-1:0] a;
        logic [2:0][DW-1:0] b;
    } job_t;

    typedef struct {
        int req; bit op; int lat; bit never; int istall; int rstall;
        int exp_grant; bit exp_err;
    } vec_t;

    int   checks = 0, errors = 0;
    job_t jq[NR][$];
    int   ph[NR];                 // per requester: 0 A pending, 1 B pending, 2 both sent
    int   mph = 0;                // job in flight: 0 none, 1 A, 2 B, 3 waiting, 4 returning
    int   owner = 0, ptr = 0, wcnt = 0, cyc = 0;
    bit   busy = 0;
    logic cur_op;
    logic [3*DW:0] exp_res;
    bit   exp_err;
    int   grant_log[$];
    // stimulus knobs
    int   lat = 0, istall = 0, rstall = 0, gpct = 0, ipct = 0, rpct = 0;
    bit   never = 0;
    // MAPU model operand capture
    logic [2:0][DW-1:0] ma, mb;
    // observations for the directed table
    int   acyc, bcyc, rcyc;
    bit   rsp_seen;
    logic last_err;

    function automatic logic [3*DW:0] mres(input logic op, input logic [2:0][DW-1:0] a,
                                           input logic [2:0][DW-1:0] b);
        logic [2:0][DW-1:0] r;
        for (int k = 0; k < 3; k++) r[k] = op ? a[k] * b[k] : a[k] + b[k];
        return {a[0][0] ^ b[0][DW-1] ^ op, r};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic op);
        job_t j;
        j.op = op;
        for (int i = 0; i < 3; i++) begin
            j.a[i] = $urandom();
            j.b[i] = $urandom();
        end
        jq[k].push_back(j);
    endtask

    task automatic drive();
        logic [3*DW:0] m;
        for (int k = 0; k < NR; k++) begin
            if (jq[k].size() > 0) begin
                req_vld[k] = (ph[k] < 2) && ($urandom_range(99) >= gpct);
                req_op[k]  = jq[k][0].op;
                req_r0[k*DW +: DW] = (ph[k] == 1) ? jq[k][0].b[0] : jq[k][0].a[0];
                req_r1[k*DW +: DW] = (ph[k] == 1) ? jq[k][0].b[1] : jq[k][0].a[1];
                req_r2[k*DW +: DW] = (ph[k] == 1) ? jq[k][0].b[2] : jq[k][0].a[2];
            end else begin
                req_vld[k] = 1'b0;
                req_op[k]  = 1'($urandom());
                req_r0[k*DW +: DW] = $urandom();
                req_r1[k*DW +: DW] = $urandom();
                req_r2[k*DW +: DW] = $urandom();
            end
            rsp_rdy[k] = ($urandom_range(99) >= rpct);
        end
        if (istall > 0 && mph == 2) begin
            mapu_i_rdy_n = 1'b0;
            istall--;
        end else begin
            mapu_i_rdy_n = ($urandom_range(99) >= ipct);
        end
        if (mph == 4 && rstall > 0) begin
            rsp_rdy[owner] = 1'b0;
            rstall--;
        end
        mapu_o_vld = (mph == 3) && !never && (wcnt >= lat);
        if (mapu_o_vld) begin
            m = mres(mapu_op, ma, mb);
            {mapu_o_of, mapu_o_r2, mapu_o_r1, mapu_o_r0} = m;
        end else begin
            {mapu_o_of, mapu_o_r2, mapu_o_r1, mapu_o_r0} = {1'($urandom()), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic observe();
        logic [NR-1:0] er;
        logic [2:0][DW-1:0] rows;
        chk("mapu_en", mapu_en, busy);
        if (busy) chk("mapu_op", mapu_op, cur_op);
        er = '0;
        if (mph == 1 || mph == 2) er[owner] = mapu_i_rdy_n;
        chk("req_rdy", req_rdy, er);
        chk("mapu_i_vld", mapu_i_vld, (mph == 1 || mph == 2) ? req_vld[owner] : 1'b0);
        if ((mph == 1 || mph == 2) && req_vld[owner]) begin
            rows = (mph == 1) ? jq[owner][0].a : jq[owner][0].b;
            chk("mapu_i_rows", {mapu_i_r2, mapu_i_r1, mapu_i_r0}, rows);
        end
        chk("mapu_o_rdy", mapu_o_rdy, mph == 3);
        er = '0;
        if (mph == 4) er[owner] = 1'b1;
        chk("rsp_vld", rsp_vld, er);
        if (mph == 4) begin
            chk("rsp_data", {rsp_of, rsp_r2, rsp_r1, rsp_r0}, exp_res);
            chk("rsp_err", rsp_err, exp_err);
        end
        if (rsp_vld != '0 && !rsp_seen) begin
            rsp_seen = 1'b1;
            rcyc = cyc;
        end
        case (mph)
            0: if (|req_vld) begin
                for (int i = NR - 1; i >= 0; i--)
                    if (req_vld[(ptr + i) % NR]) owner = (ptr + i) % NR;
                busy = 1'b1;
                mph = 1;
                cur_op = jq[owner][0].op;
                grant_log.push_back(owner);
                rsp_seen = 1'b0;
            end
            1: if (req_vld[owner] && mapu_i_rdy_n) begin
                ma = {mapu_i_r2, mapu_i_r1, mapu_i_r0};
                ph[owner] = 1; mph = 2; acyc = cyc;
            end
            2: if (req_vld[owner] && mapu_i_rdy_n) begin
                mb = {mapu_i_r2, mapu_i_r1, mapu_i_r0};
                ph[owner] = 2; mph = 3; wcnt = 0; bcyc = cyc;
            end
            3: if (mapu_o_vld) begin
                exp_res = mres(jq[owner][0].op, jq[owner][0].a, jq[owner][0].b);
                exp_err = 1'b0; mph = 4;
            end else if (wcnt == TMO - 1) begin
                exp_res = '0; exp_err = 1'b1; mph = 4;
            end else begin
                wcnt++;
            end
            4: if (rsp_rdy[owner]) begin
                last_err = rsp_err;
                void'(jq[owner].pop_front());
                ph[owner] = 0;
                ptr = (owner + 1) % NR;
                busy = 1'b0; mph = 0;
            end
            default: mph = 0;
        endcase
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        observe();
        cyc++;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while (!(jq[0].size() == 0 && jq[1].size() == 0 && mph == 0) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL idle_budget actual=%0d expected<%0d", n, budget);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_rdy"}, req_rdy, 0);
        chk({tag, "_rsp_vld"}, rsp_vld, 0);
        chk({tag, "_rsp_r0"}, rsp_r0, 0);
        chk({tag, "_rsp_r1"}, rsp_r1, 0);
        chk({tag, "_rsp_r2"}, rsp_r2, 0);
        chk({tag, "_rsp_of"}, rsp_of, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_mapu_en"}, mapu_en, 0);
        chk({tag, "_mapu_op"}, mapu_op, 0);
        chk({tag, "_mapu_i_vld"}, mapu_i_vld, 0);
        chk({tag, "_mapu_o_rdy"}, mapu_o_rdy, 0);
        chk({tag, "_mapu_i_r0"}, mapu_i_r0, 0);
    endtask

    task automatic clear_model();
        for (int k = 0; k < NR; k++) begin
            jq[k].delete();
            ph[k] = 0;
        end
        mph = 0; busy = 1'b0; ptr = 0; never = 1'b0; istall = 0; rstall = 0;
        req_vld = '0; mapu_o_vld = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int   glen, n;
        vt[0] = '{0, 1'b1, 5, 1'b0, 0, 0, 0, 1'b0};
        vt[1] = '{1, 1'b0, 0, 1'b0, 0, 0, 1, 1'b0};
        vt[2] = '{0, 1'b1, 3, 1'b0, 3, 4, 0, 1'b0};
        vt[3] = '{1, 1'b0, 7, 1'b0, 0, 0, 1, 1'b0};
        vt[4] = '{0, 1'b0, 0, 1'b1, 0, 0, 0, 1'b1};
        vt[5] = '{1, 1'b1, 0, 1'b1, 0, 0, 1, 1'b1};

        reset_n = 1'b0;
        req_vld = '0; req_op = '0; req_r0 = '0; req_r1 = '0; req_r2 = '0;
        rsp_rdy = '0; mapu_i_rdy_n = 1'b0; mapu_o_vld = 1'b0; mapu_o_of = 1'b0;
        mapu_o_r0 = '0; mapu_o_r1 = '0; mapu_o_r2 = '0;
        ph[0] = 0; ph[1] = 0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // directed single jobs, no random backpressure
        foreach (vt[i]) begin
            lat = vt[i].lat; never = vt[i].never;
            istall = vt[i].istall; rstall = vt[i].rstall;
            push(vt[i].req, vt[i].op);
            run_until_idle(100);
            chk($sformatf("vec%0d_grant", i), grant_log[grant_log.size() - 1], vt[i].exp_grant);
            chk($sformatf("vec%0d_err", i), last_err, vt[i].exp_err);
            chk($sformatf("vec%0d_rsp_delay", i), rcyc - bcyc,
                vt[i].never ? TMO + 1 : vt[i].lat + 2);
            if (vt[i].istall == 0)
                chk($sformatf("vec%0d_ab_back2back", i), bcyc - acyc, 1);
            else
                chk($sformatf("vec%0d_b_stall", i), bcyc - acyc, vt[i].istall + 1);
        end
        never = 1'b0;

        // both requesters busy for four jobs, pointer at 0 after a requester 1 job
        lat = 2;
        push(0, 1'b0); push(0, 1'b1); push(1, 1'b1); push(1, 1'b0);
        glen = grant_log.size();
        run_until_idle(200);
        for (int i = 0; i < 4; i++)
            chk($sformatf("alt_grant%0d", i), grant_log[glen + i], i % 2);

        // random traffic with backpressure and occasional timeouts
        gpct = 25; ipct = 30; rpct = 40;
        for (int j = 0; j < 40; j++) begin
            lat = $urandom_range(9);
            push($urandom_range(NR - 1), 1'($urandom()));
            repeat ($urandom_range(12)) cycle();
        end
        run_until_idle(3000);
        gpct = 0; ipct = 0; rpct = 0;

        // move pointer to 1, then reset while requester 1's job waits for the MAPU
        lat = 3;
        push(0, 1'b0);
        run_until_idle(100);
        never = 1'b1;
        push(1, 1'b1);
        n = 0;
        while (!(mph == 3 && wcnt == 3) && n < 100) begin
            cycle();
            n++;
        end
        chk("reach_wait_rsp", n < 100, 1'b1);
        chk("pre_rst_o_rdy", mapu_o_rdy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        clear_model();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push(1, 1'b0); push(0, 1'b1);
        glen = grant_log.size();
        run_until_idle(100);
        chk("post_rst_first_grant", grant_log[glen], 0);
        chk("post_rst_second_grant", grant_log[glen + 1], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
